// File: rtl/elastic_buffer_if.sv
// Ready/valid channel bundle used on both sides of the elastic buffer.
// master drives valid/data and observes ready; slave observes valid/data and drives ready.
interface elastic_buffer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/elastic_buffer.sv
// elastic_buffer: DEPTH-entry ready/valid FIFO stage with registered handshakes.
// up_ready, down_valid and count are registers; down_data is a mux over storage
// registers only, so no combinational path joins the up and down ports.
// Optional feature: define ELASTIC_BUFFER_FLUSH_EN to add a synchronous flush input
// that empties the buffer (pointers/count/handshakes) while keeping storage contents.
module elastic_buffer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter string       NAME  = ""
) (
  input  logic                       clock,
  input  logic                       reset,
  elastic_buffer_if.slave            up,
  elastic_buffer_if.master           down,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef ELASTIC_BUFFER_FLUSH_EN
  ,
  input  logic                       flush
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             up_ready_q;
  logic             down_valid_q;
  logic             push_c;
  logic             pop_c;
  logic             flush_c;
  logic [CW-1:0]    count_next_c;
  logic [PW-1:0]    wr_ptr_inc_c;
  logic [PW-1:0]    rd_ptr_inc_c;

`ifdef ELASTIC_BUFFER_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  assign push_c     = up.valid & up_ready_q;
  assign pop_c      = down_valid_q & down.ready;
  assign up.ready   = up_ready_q;
  assign down.valid = down_valid_q;
  assign down.data  = mem[rd_ptr];

  // Pointer increment with wrap at DEPTH-1 (DEPTH need not be a power of two).
  always_comb begin
    wr_ptr_inc_c = wr_ptr + PW'(1);
    rd_ptr_inc_c = rd_ptr + PW'(1);
    if (wr_ptr == PW'(DEPTH - 1)) wr_ptr_inc_c = '0;
    if (rd_ptr == PW'(DEPTH - 1)) rd_ptr_inc_c = '0;
  end

  // Occupancy after this edge; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next_c = count;
    if (push_c && !pop_c) begin
      count_next_c = count + CW'(1);
    end else if (!push_c && pop_c) begin
      count_next_c = count - CW'(1);
    end
  end

  // Storage, pointers and registered handshakes; reset beats flush beats push/pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      down_valid_q <= 1'b0;
      up_ready_q   <= 1'b1;
    end else if (flush_c) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      down_valid_q <= 1'b0;
      up_ready_q   <= 1'b1;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= up.data;
        wr_ptr      <= wr_ptr_inc_c;
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr_inc_c;
      end
      count        <= count_next_c;
      down_valid_q <= (count_next_c != '0);
      up_ready_q   <= (count_next_c != CW'(DEPTH));
    end
  end

`ifndef SYNTHESIS
  // Overflow guard: a push must never be accepted while the buffer is full.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(push_c && (count == CW'(DEPTH))))
        else $error("%s: push accepted while full", NAME);
    end
  end
`endif

endmodule
